// File: rtl/alu_shifter_unit.sv
// EX-stage execute block: bit-sliced 32-bit ALU (AND/OR/ADD/SLT with operand
// inversion) plus an independent logical barrel shifter, both registered.

// One ALU bit: optional operand inversion, AND/OR, full adder and the SLT
// "less" input, which is non-zero only for bit 0.
module alu_slice (
  input  logic       src_a,
  input  logic       src_b,
  input  logic       invert_a,
  input  logic       invert_b,
  input  logic       carry_in,
  input  logic       less,
  input  logic [1:0] operation,
  output logic       result,
  output logic       sum,
  output logic       carry_out
);

  logic a;
  logic b;

  assign a         = invert_a ? ~src_a : src_a;
  assign b         = invert_b ? ~src_b : src_b;
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

  always_comb begin
    // NOTE: default assignment first, so no path can leave result unassigned
    // and infer a latch.
    result = 1'b0;
    unique case (operation)
      2'b00:   result = a & b;
      2'b01:   result = a | b;
      2'b10:   result = sum;
      2'b11:   result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

module alu_shifter_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  alu_src1,
  input  logic [DATA_W-1:0]  alu_src2,
  input  logic               invert_a,
  input  logic               invert_b,
  input  logic [1:0]         operation,
  input  logic [DATA_W-1:0]  sft_src,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               left_right,
  output logic [DATA_W-1:0]  alu_result,
  output logic               zero,
  output logic               overflow,
  output logic [DATA_W-1:0]  sft_result
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } alu_op_e;

  // ---------------------------------------------------------------------------
  // ALU: ripple chain of slices; carry-in of bit 0 is invert_b so that
  // invert_b=1 turns ADD into two's-complement subtract.
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   carry;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] alu_next;
  logic              ovf;
  logic              set;
  alu_op_e           op;

  assign op       = alu_op_e'(operation);
  assign carry[0] = invert_b;

  genvar i;
  generate
    for (i = 0; i < DATA_W; i++) begin : g_slice
      alu_slice u_slice (
        .src_a     (alu_src1[i]),
        .src_b     (alu_src2[i]),
        .invert_a  (invert_a),
        .invert_b  (invert_b),
        .carry_in  (carry[i]),
        .less      ((i == 0) ? set : 1'b0),
        .operation (operation),
        .result    (alu_next[i]),
        .sum       (sum[i]),
        .carry_out (carry[i+1])
      );
    end
  endgenerate

  // Signed overflow: carry into the sign bit differs from carry out of it.
  // SLT uses the corrected sign so A < B holds even when A - B overflows.
  assign ovf = carry[DATA_W-1] ^ carry[DATA_W];
  assign set = sum[DATA_W-1] ^ ovf;

  logic ovf_next;
  logic zero_next;

  assign ovf_next  = ((op == OP_ADD) || (op == OP_SLT)) ? ovf : 1'b0;
  assign zero_next = (alu_next == '0);

  // ---------------------------------------------------------------------------
  // Shifter: five log stages (1,2,4,8,16), each conditionally shifting by its
  // power of two in the selected direction; vacated bits fill with zero.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] stage [0:SHAMT_W];

  assign stage[0] = sft_src;

  genvar s;
  generate
    for (s = 0; s < SHAMT_W; s++) begin : g_stage
      localparam int STEP = 1 << s;
      logic [DATA_W-1:0] shifted;
      assign shifted = left_right ? (stage[s] << STEP) : (stage[s] >> STEP);
      assign stage[s+1] = shamt[s] ? shifted : stage[s];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output registers: one cycle of latency, cleared asynchronously.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      alu_result <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      sft_result <= '0;
    end else begin
      alu_result <= alu_next;
      zero       <= zero_next;
      overflow   <= ovf_next;
      sft_result <= stage[SHAMT_W];
    end
  end

endmodule

// File: tb/tb_alu_shifter_unit.sv
// Self-checking bench for alu_shifter_unit: directed corner cases plus
// randomized back-to-back vectors against an arithmetic reference model.

module tb_alu_shifter_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic        invert_a;
  logic        invert_b;
  logic [1:0]  operation;
  logic [31:0] sft_src;
  logic [4:0]  shamt;
  logic        left_right;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;
  logic [31:0] sft_result;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic        ovf;
    logic [31:0] sft;
  } expect_t;

  alu_shifter_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .invert_a   (invert_a),
    .invert_b   (invert_b),
    .operation  (operation),
    .sft_src    (sft_src),
    .shamt      (shamt),
    .left_right (left_right),
    .alu_result (alu_result),
    .zero       (zero),
    .overflow   (overflow),
    .sft_result (sft_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: whole-word arithmetic and signed comparison, no slices.
  function automatic expect_t model(input logic [31:0] s1, input logic [31:0] s2,
                                    input logic ia, input logic ib, input logic [1:0] op,
                                    input logic [31:0] ss, input logic [4:0] sh, input logic lr);
    expect_t     e;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] full;
    logic        v;
    a    = ia ? ~s1 : s1;
    b    = ib ? ~s2 : s2;
    full = {1'b0, a} + {1'b0, b} + {32'd0, ib};
    // Signed overflow: both addends share a sign and the sum's sign differs.
    v    = (a[31] == b[31]) && (full[31] != a[31]);
    case (op)
      2'b00:   e.alu = a & b;
      2'b01:   e.alu = a | b;
      2'b10:   e.alu = full[31:0];
      default: e.alu = {31'd0, full[31] ^ v};
    endcase
    e.ovf  = (op[1] == 1'b1) ? v : 1'b0;
    e.zero = (e.alu == 32'd0);
    e.sft  = lr ? (ss << sh) : (ss >> sh);
    return e;
  endfunction

  task automatic drive(input logic [31:0] s1, input logic [31:0] s2, input logic ia,
                       input logic ib, input logic [1:0] op, input logic [31:0] ss,
                       input logic [4:0] sh, input logic lr);
    alu_src1 = s1; alu_src2 = s2; invert_a = ia; invert_b = ib;
    operation = op; sft_src = ss; shamt = sh; left_right = lr;
  endtask

  // Apply one vector, clock it in, compare all outputs 1 ns after the edge.
  task automatic run(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                     input logic ia, input logic ib, input logic [1:0] op,
                     input logic [31:0] ss, input logic [4:0] sh, input logic lr);
    expect_t e;
    drive(s1, s2, ia, ib, op, ss, sh, lr);
    e = model(s1, s2, ia, ib, op, ss, sh, lr);
    @(posedge clk);
    #1;
    check({tag, ".alu"},  alu_result,        e.alu);
    check({tag, ".zero"}, {31'd0, zero},     {31'd0, e.zero});
    check({tag, ".ovf"},  {31'd0, overflow}, {31'd0, e.ovf});
    check({tag, ".sft"},  sft_result,        e.sft);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.alu", alu_result, 32'd0);
    check("rst.zero", {31'd0, zero}, 32'd0);
    check("rst.sft", sft_result, 32'd0);
    rst_n = 1'b1;

    // Load nonzero results, then assert reset mid-cycle.
    run("pre_rst", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 2'b10, 32'hFFFF_FFFF, 5'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.alu", alu_result, 32'd0);
    check("async_rst.ovf", {31'd0, overflow}, 32'd0);
    check("async_rst.sft", sft_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst_add", 32'd1, 32'd1, 1'b0, 1'b0, 2'b10, 32'd0, 5'd0, 1'b0);
    check("post_rst_add.literal", alu_result, 32'd2);

    // Logic ops.
    run("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 2'b00, 32'd0, 5'd0, 1'b0);
    check("and.literal", alu_result, 32'hF000_F000);
    run("or",  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 2'b01, 32'd0, 5'd0, 1'b0);
    check("or.literal", alu_result, 32'hFFF0_FFF0);
    run("nor", 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b1, 2'b00, 32'd0, 5'd0, 1'b0);
    check("nor.literal", alu_result, 32'h000F_000F);
    run("nand", 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b1, 2'b01, 32'd0, 5'd0, 1'b0);

    // Arithmetic.
    run("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 2'b10, 32'd0, 5'd0, 1'b0);
    check("add_ovf.literal", {alu_result[31:1], overflow}, {31'h4000_0000, 1'b1});
    run("sub_zero", 32'd5, 32'd5, 1'b0, 1'b1, 2'b10, 32'd0, 5'd0, 1'b0);
    check("sub_zero.literal", {alu_result[30:0], zero}, {31'd0, 1'b1});
    run("sub_neg_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 2'b10, 32'd0, 5'd0, 1'b0);

    // Set-less-than.
    run("slt_m1_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 2'b11, 32'd0, 5'd0, 1'b0);
    check("slt_m1_1.literal", alu_result, 32'd1);
    run("slt_min_1", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 2'b11, 32'd0, 5'd0, 1'b0);
    check("slt_min_1.literal", alu_result, 32'd1);
    run("slt_5_3", 32'd5, 32'd3, 1'b0, 1'b1, 2'b11, 32'd0, 5'd0, 1'b0);
    check("slt_5_3.literal", {alu_result[31:1], zero}, {31'd0, 1'b1});

    // Shifter corners.
    run("sr1", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'h8000_0001, 5'd1, 1'b0);
    check("sr1.literal", sft_result, 32'h4000_0000);
    run("sl4", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'h8000_0001, 5'd4, 1'b1);
    check("sl4.literal", sft_result, 32'h0000_0010);
    run("sh0", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'h8000_0001, 5'd0, 1'b1);
    check("sh0.literal", sft_result, 32'h8000_0001);
    run("sl31", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd1, 5'd31, 1'b1);
    check("sl31.literal", sft_result, 32'h8000_0000);
    run("sr31", 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 5'd31, 1'b0);
    check("sr31.literal", sft_result, 32'd1);

    // Independence: fixed ALU inputs, changing shifter inputs, and vice versa.
    for (int k = 0; k < 4; k++) begin
      run("indep_alu", 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1, 2'b10,
          $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      run("indep_sft", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 32'hA5A5_0FF0, 5'd7, 1'b0);
    end

    // Back-to-back random vectors, new inputs every cycle.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] r1;
      logic [31:0] r2;
      r1 = $urandom;
      r2 = (k % 10 == 0) ? r1 : $urandom;
      if (k % 7 == 0) r1 = {r1[31], {31{~r1[31]}}};
      run("rand", r1, r2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
